rv32_uart_tx: RTL and testbench
===============================

Name: rv32_uart_tx

Overview:
Memory-mapped UART transmitter on the core's data port, in parallel with the unified memory's port B. It decodes the same data address, write-enable and write-data bus the RAM sees, and returns registered read data with the RAM's one-cycle latency. The top level muxes its read data against the RAM's using hit_o. Written bytes are buffered in a FIFO and serialised 8N1, LSB first, onto uart_tx_o.

Parameters:
CLK_FREQ_HZ, 100000000, system clock frequency in Hz.
BAUD_RATE, 115200, serial bit rate; DIV = CLK_FREQ_HZ / BAUD_RATE (integer, truncated), DIV ≥ 2.
FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..128.
BASE_ADDR, 32'h0001_0000, register block base; 16-byte aligned.

Ports:
clk_i  in  1  system clock, rising edge.
rst_n_i  in  1  reset, asynchronous, active-low.
data_address_i  in  32  core data address (byte address).
write_data_i  in  32  core store data.
write_enable_i  in  4  per-byte write strobes; any bit set marks a write.
read_data_o  out  32  registered register readback.
hit_o  out  1  registered decode hit, aligned with read_data_o.
uart_tx_o  out  1  serial line, idle high.
irq_o  out  1  TX-empty interrupt, level.

Behaviour:
- Reset state: uart_tx_o=1, read_data_o=0, hit_o=0, irq_o=0, FIFO empty, overflow=0, CTRL=32'h1, FSM=IDLE, baud counter=0.
- Decode: sel = (data_address_i[31:4] == BASE_ADDR[31:4]); offset = data_address_i[3:2].
  - 0 TXDATA: write with write_enable_i[0] pushes write_data_i[7:0]; reads 0.
  - 1 STATUS (RO except W1C): bit0 full, bit1 empty, bit2 busy (FSM≠IDLE), bit3 overflow, [15:8] FIFO level, rest 0. Writing 1 to bit3 with write_enable_i[0] clears overflow.
  - 2 CTRL: bit0 tx_en, bit1 irq_en; byte lane 0 writable; other bits read 0.
  - 3: reserved; writes ignored, reads 0.
- Read: every cycle, read_data_o <= selected register at the current address; hit_o <= sel. Latency is 1 cycle. When sel=0, read_data_o=0.
- Push accepted if !full, or if a pop occurs in the same cycle (level unchanged). Otherwise the byte is dropped and overflow is set (sticky). If a clear and a new overflow land in the same cycle, set wins.
- FSM:
  - IDLE: when tx_en and !empty, pop a byte into the shift register, go to START, load counter with DIV-1.
  - START: uart_tx_o=0 for DIV cycles, then DATA.
  - DATA: 8 bits LSB first, DIV cycles each, then STOP.
  - STOP: uart_tx_o=1 for DIV cycles, then IDLE.
  - uart_tx_o is driven from a register.
- Frame length is exactly 10*DIV cycles. Back-to-back frames add exactly one IDLE cycle between STOP and the next START.
- tx_en cleared mid-frame: the current frame completes and no further pops occur. The FIFO contents are retained.
- irq_o = irq_en & empty & !busy, registered (1 cycle behind state).
- Misaligned or partial-strobe writes to TXDATA: only write_enable_i[0] matters.
- Asynchronous reset mid-frame: the line returns high immediately and the FIFO contents are lost.

Optional Feature:
UART_TX_PARITY_EN
- Defined: a parity bit follows the 8th data bit. CTRL bit2 (par_odd) selects the type: 0 gives even, 1 gives odd. New FSM state PARITY; frame length is 11*DIV cycles.
- Undefined: no PARITY state, CTRL bit2 reads 0 and ignores writes, frames are 8N1.

Decomposition:
- Package rv32_uart_pkg: FSM state enum (IDLE/START/DATA/PARITY/STOP), register offset localparams (OFF_TXDATA=0, OFF_STATUS=1, OFF_CTRL=2), STATUS/CTRL bit-position constants, CTRL reset value.
- Sub-module rv32_sync_fifo: parameterised width/depth, push/pop, full/empty/level, same clk_i/rst_n_i. Pointers one bit wider than the address to distinguish full from empty.

Test Plan (CLK_FREQ_HZ=100000000, BAUD_RATE=10000000 → DIV=10):
- Write 32'h55 to BASE+0 → uart_tx_o low for 10 cycles, then 1,0,1,0,1,0,1,0 for 10 cycles each, high for 10 cycles. Total 100 cycles; STATUS bit2 high throughout.
- Write 17 bytes back-to-back with tx_en=0 → STATUS reads full=1, level=16, overflow=1. Write 32'h8 to STATUS → overflow=0 on next read.
- Read CTRL (BASE+8) → read_data_o=32'h1 and hit_o=1 exactly one cycle after the address. Read address 32'h0 → hit_o=0, read_data_o=0.
- Set irq_en, send 2 bytes → irq_o=0 while busy. irq_o rises 1 cycle after the second STOP ends. Frames are separated by exactly 1 idle cycle.
- Assert rst_n_i low during DATA of byte 0xA3 → uart_tx_o=1 and STATUS empty immediately, with no clock edge needed.
- With UART_TX_PARITY_EN and CTRL=32'h1, send 32'h07 → parity bit 1 (even) before stop, frame 110 cycles. With CTRL=32'h5 → parity bit 0.

Source files
------------

// File: rtl/rv32_uart_pkg.sv
// Shared state encoding and register map for the rv32 UART transmitter.
// No ports; imported by rv32_sync_fifo users and rv32_uart_tx.
package rv32_uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_CTRL   = 2'd2;

   localparam int ST_FULL_BIT  = 0;
   localparam int ST_EMPTY_BIT = 1;
   localparam int ST_BUSY_BIT  = 2;
   localparam int ST_OVF_BIT   = 3;
   localparam int ST_LVL_LSB   = 8;

   localparam int CT_TXEN_BIT   = 0;
   localparam int CT_IRQEN_BIT  = 1;
   localparam int CT_PARODD_BIT = 2;

   localparam logic [31:0] CTRL_RST = 32'h1;

endpackage

// File: rtl/rv32_sync_fifo.sv
// Synchronous FIFO with one-bit-wider pointers for full/empty split.
// Ports: clk_i, rst_n_i, push/wdata in, pop in, rdata/full/empty/level out.
module rv32_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + (AW+1)'(1);
         if (pop)  rptr <= rptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rptr[AW-1:0]];
   assign level = wptr - rptr;
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) &&
                  (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/rv32_uart_tx.sv
// Memory-mapped 8N1 UART transmitter beside RAM port B; optional parity via UART_TX_PARITY_EN.
// Ports: clk_i, rst_n_i, data_address_i, write_data_i, write_enable_i in; read_data_o, hit_o, uart_tx_o, irq_o out.
module rv32_uart_tx
   import rv32_uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 100000000,
   parameter int unsigned BAUD_RATE   = 115200,
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter logic [31:0] BASE_ADDR   = 32'h0001_0000
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] data_address_i,
   input  logic [31:0] write_data_i,
   input  logic [3:0]  write_enable_i,
   output logic [31:0] read_data_o,
   output logic        hit_o,
   output logic        uart_tx_o,
   output logic        irq_o
);

   localparam int unsigned DIV = CLK_FREQ_HZ / BAUD_RATE;
   localparam int CW = $clog2(DIV);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(DIV - 1);

   logic          sel;
   logic [1:0]    off;
   logic          wr0;
   logic          push_req;
   logic          push;
   logic          pop;
   logic          clr_ovf;
   logic          ctrl_wr;
   logic          full;
   logic          empty;
   logic [LW-1:0] level;
   logic [7:0]    fifo_rdata;
   logic          ovf;
   logic          tx_en;
   logic          irq_en;
   logic          par_odd;
   logic [31:0]   status_w;
   logic [31:0]   ctrl_w;
   logic [31:0]   reg_w;
   state_t        state;
   logic [CW-1:0] cnt;
   logic [7:0]    shreg;
   logic [2:0]    bit_idx;
   logic          tx;
`ifdef UART_TX_PARITY_EN
   logic          par_bit;
`endif

   // Byte lanes 1..3, sub-word address bits and upper data are don't-care.
   logic unused_bits;
   assign unused_bits = ^{data_address_i[1:0], write_data_i[31:8],
                          write_enable_i[3:1]};

   assign sel      = (data_address_i[31:4] == BASE_ADDR[31:4]);
   assign off      = data_address_i[3:2];
   assign wr0      = sel & write_enable_i[0];
   assign push_req = wr0 & (off == OFF_TXDATA);
   assign clr_ovf  = wr0 & (off == OFF_STATUS) & write_data_i[ST_OVF_BIT];
   assign ctrl_wr  = wr0 & (off == OFF_CTRL);

   assign pop  = (state == ST_IDLE) & tx_en & ~empty;
   // A same-cycle pop frees the slot being written.
   assign push = push_req & (~full | pop);

   rv32_sync_fifo #(
      .WIDTH (8),
      .DEPTH (int'(FIFO_DEPTH))
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push    (push),
      .wdata   (write_data_i[7:0]),
      .pop     (pop),
      .rdata   (fifo_rdata),
      .full    (full),
      .empty   (empty),
      .level   (level)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tx_en  <= CTRL_RST[CT_TXEN_BIT];
         irq_en <= CTRL_RST[CT_IRQEN_BIT];
      end else if (ctrl_wr) begin
         tx_en  <= write_data_i[CT_TXEN_BIT];
         irq_en <= write_data_i[CT_IRQEN_BIT];
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)     par_odd <= CTRL_RST[CT_PARODD_BIT];
      else if (ctrl_wr) par_odd <= write_data_i[CT_PARODD_BIT];
   end
`else
   assign par_odd = 1'b0;
`endif

   // Sticky overflow; a new drop beats a same-cycle clear.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)              ovf <= 1'b0;
      else if (push_req & ~push) ovf <= 1'b1;
      else if (clr_ovf)          ovf <= 1'b0;
   end

   always_comb begin
      status_w = '0;
      status_w[ST_FULL_BIT]  = full;
      status_w[ST_EMPTY_BIT] = empty;
      status_w[ST_BUSY_BIT]  = (state != ST_IDLE);
      status_w[ST_OVF_BIT]   = ovf;
      status_w[ST_LVL_LSB +: 8] = 8'(level);
      ctrl_w = '0;
      ctrl_w[CT_TXEN_BIT]   = tx_en;
      ctrl_w[CT_IRQEN_BIT]  = irq_en;
      ctrl_w[CT_PARODD_BIT] = par_odd;
      reg_w = '0;
      unique case (1'b1)
         (off == OFF_STATUS): reg_w = status_w;
         (off == OFF_CTRL):   reg_w = ctrl_w;
         default:             reg_w = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         read_data_o <= '0;
         hit_o       <= 1'b0;
         irq_o       <= 1'b0;
      end else begin
         read_data_o <= sel ? reg_w : 32'h0;
         hit_o       <= sel;
         irq_o       <= irq_en & empty & (state == ST_IDLE);
      end
   end

   // Each state holds DIV cycles: counter loads DIV-1, advances at 0.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         shreg   <= '0;
         bit_idx <= '0;
         tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_bit <= 1'b0;
`endif
      end else begin
         unique case (state)
            ST_IDLE: begin
               tx <= 1'b1;
               if (pop) begin
                  shreg   <= fifo_rdata;
                  cnt     <= CNT_LOAD;
                  bit_idx <= '0;
                  tx      <= 1'b0;
                  state   <= ST_START;
`ifdef UART_TX_PARITY_EN
                  par_bit <= (^fifo_rdata) ^ par_odd;
`endif
               end
            end
            ST_START: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  cnt   <= CNT_LOAD;
                  tx    <= shreg[0];
                  shreg <= shreg >> 1;
                  state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  cnt <= CNT_LOAD;
                  if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     tx    <= par_bit;
                     state <= ST_PARITY;
`else
                     tx    <= 1'b1;
                     state <= ST_STOP;
`endif
                  end else begin
                     tx      <= shreg[0];
                     shreg   <= shreg >> 1;
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  cnt   <= CNT_LOAD;
                  tx    <= 1'b1;
                  state <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  tx    <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign uart_tx_o = tx;

endmodule

// File: tb/tb_rv32_uart_tx.sv
// Scoreboarded bench for rv32_uart_tx: serial frames checked against a byte queue model,
// plus register map, overflow, irq timing, tx_en gating and async reset checks.
`timescale 1ns/1ps
module tb_rv32_uart_tx;

   localparam int unsigned DIV = 10;
   localparam int DEPTH = 16;
   localparam logic [31:0] BASE = 32'h0001_0000;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
   localparam logic [31:0] CTRL_MASK = 32'h7;
`else
   localparam int NB = 10;
   localparam logic [31:0] CTRL_MASK = 32'h3;
`endif
   localparam int FLEN = NB * int'(DIV);

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  we = '0;
   logic [31:0] rdata;
   logic        hit;
   logic        tx;
   logic        irq;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   logic [8:0] exp_q[$];
   int starts[$];
   bit in_frame = 0;
   bit abort_ok = 0;
   bit cur_odd = 0;

   rv32_uart_tx #(
      .CLK_FREQ_HZ (100000000),
      .BAUD_RATE   (10000000),
      .FIFO_DEPTH  (DEPTH),
      .BASE_ADDR   (BASE)
   ) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .data_address_i (addr),
      .write_data_i   (wdata),
      .write_enable_i (we),
      .read_data_o    (rdata),
      .hit_o          (hit),
      .uart_tx_o      (tx),
      .irq_o          (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: decode every frame on the line and pop the scoreboard.
   initial begin : monitor
      logic [8:0]    e;
      logic [NB-1:0] bits;
      logic [7:0]    got;
      logic          s;
      int            bad;
      bit            ab;
      forever begin
         @(negedge clk);
         if (rst_n && tx === 1'b0) begin
            starts.push_back(cyc);
            in_frame = 1;
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_frame: got a start bit, required idle line");
               e = '0;
            end else begin
               e = exp_q.pop_front();
            end
            bits = '0;
            for (int i = 0; i < 8; i++) bits[1+i] = e[i];
`ifdef UART_TX_PARITY_EN
            bits[9] = (^e[7:0]) ^ e[8];
`endif
            bits[NB-1] = 1'b1;
            bad = -1;
            ab = 0;
            got = '0;
            for (int k = 0; k < FLEN; k++) begin
               if (k > 0) @(negedge clk);
               if (!rst_n) begin
                  ab = 1;
                  break;
               end
               s = tx;
               if (s !== bits[k / int'(DIV)] && bad < 0) bad = k;
               if ((k % int'(DIV)) == int'(DIV) / 2 &&
                   k / int'(DIV) >= 1 && k / int'(DIV) <= 8)
                  got[k / int'(DIV) - 1] = s;
            end
            if (ab) begin
               if (abort_ok) begin
                  exp_q.delete();
                  abort_ok = 0;
               end else begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL frame_abort: got reset mid-frame, required full frame");
               end
            end else begin
               check("frame_first_bad_sample", bad, 32'hFFFF_FFFF);
               check("frame_byte", {24'b0, got}, {24'b0, e[7:0]});
            end
            in_frame = 0;
         end
      end
   end

   task automatic idle(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s);
      addr = a;
      wdata = d;
      we = s;
      @(posedge clk);
      #1;
      addr = '0;
      wdata = '0;
      we = '0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp_d,
                     input logic exp_h, input string nm);
      addr = a;
      we = '0;
      @(posedge clk);
      #1;
      check({nm, "_hit"}, {31'b0, hit}, {31'b0, exp_h});
      check(nm, rdata, exp_d);
      addr = '0;
   endtask

   task automatic wr_ctrl(input logic [31:0] v);
      wr(BASE + 32'h8, v, 4'h1);
      cur_odd = v[2] & CTRL_MASK[2];
   endtask

   // force_lane0=0 randomises strobes; only lane 0 should push.
   task automatic send(input logic [7:0] b, input bit force_lane0);
      logic [3:0] s;
      s = 4'($urandom_range(1, 15));
      if (force_lane0) s[0] = 1'b1;
      wr(BASE | 32'($urandom_range(0, 3)), {24'($urandom), b}, s);
      if (s[0]) exp_q.push_back({cur_odd, b});
   endtask

   task automatic wait_frames(input int n);
      int k;
      k = 0;
      do begin
         @(posedge clk);
         k++;
      end while (starts.size() < n && k < 2000);
      #1;
      n_chk++;
      if (starts.size() < n) begin
         n_fail++;
         $display("FAIL frame_start_timeout: got %0d frames, required %0d",
                  starts.size(), n);
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      do begin
         @(posedge clk);
         k++;
      end while ((exp_q.size() != 0 || in_frame) && k < 4000);
      idle(3);
      n_chk++;
      if (exp_q.size() != 0 || in_frame) begin
         n_fail++;
         $display("FAIL drain_timeout: got %0d bytes pending, required 0",
                  exp_q.size());
      end
   endtask

   initial begin : stim
      int n0;
      int lvl;
      int k;
      int rise;
      logic [7:0] b;

      idle(3);
      check("rst_tx", {31'b0, tx}, 32'h1);
      check("rst_rdata", rdata, 32'h0);
      check("rst_hit", {31'b0, hit}, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);
      rst_n = 1'b1;
      idle(2);

      rd(BASE + 32'h8, 32'h1, 1'b1, "ctrl_reset");
      rd(32'h0, 32'h0, 1'b0, "miss_read");
      rd(BASE + 32'h4, 32'h2, 1'b1, "status_reset");
      rd(BASE + 32'hC, 32'h0, 1'b1, "reserved_read");

      // 0x55 frame with busy polled throughout.
      send(8'h55, 1'b1);
      idle(2);
      for (int i = 0; i < 9; i++) begin
         rd(BASE + 32'h4, 32'h6, 1'b1, "status_busy");
         idle(9);
      end
      drain();

      wr_ctrl(32'h5);
      rd(BASE + 32'h8, 32'h5 & CTRL_MASK, 1'b1, "ctrl_par_bit");
      wr_ctrl(32'h1);
      send(8'h07, 1'b1);
      drain();
      wr_ctrl(32'h5);
      send(8'h07, 1'b1);
      drain();

      // irq low while busy, rises one cycle after last STOP.
      wr_ctrl(32'h3);
      idle(3);
      check("irq_idle", {31'b0, irq}, 32'h1);
      n0 = starts.size();
      send(8'hC3, 1'b1);
      send(8'h3C, 1'b1);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (irq !== 1'b1 && k < 3 * FLEN);
      rise = cyc;
      idle(1);
      if (starts.size() >= n0 + 2) begin
         check("frame_gap", starts[n0+1] - starts[n0], FLEN + 1);
         check("irq_rise", rise, starts[n0+1] + FLEN + 1);
      end else begin
         n_chk++;
         n_fail++;
         $display("FAIL irq_frames: got %0d frames, required 2",
                  starts.size() - n0);
      end
      drain();

      // Overflow with transmitter disabled.
      wr_ctrl(32'h0);
      lvl = 0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         b = 8'($urandom);
         wr(BASE, {24'($urandom), b}, 4'h1);
         if (lvl < DEPTH) begin
            exp_q.push_back({cur_odd, b});
            lvl++;
         end
      end
      rd(BASE + 32'h4, 32'h0000_1009, 1'b1, "status_ovf");
      check("irq_disabled", {31'b0, irq}, 32'h0);
      wr(BASE + 32'h4, 32'h8, 4'h1);
      rd(BASE + 32'h4, 32'h0000_1001, 1'b1, "status_ovf_clr");
      wr_ctrl(32'h1);
      drain();

      // tx_en dropped mid-frame: frame finishes, rest retained.
      n0 = starts.size();
      send(8'h11, 1'b1);
      send(8'h22, 1'b1);
      send(8'h33, 1'b1);
      wait_frames(n0 + 1);
      idle(5);
      wr_ctrl(32'h0);
      idle(FLEN + 20);
      rd(BASE + 32'h4, 32'h0000_0200, 1'b1, "status_held");
      check("held_frames", starts.size() - n0, 32'd1);
      check("held_queue", exp_q.size(), 32'd2);
      wr_ctrl(32'h1);
      drain();

      // Random bursts with random parity type and strobes.
      for (int j = 0; j < 6; j++) begin
         wr_ctrl({29'b0, 1'($urandom), 2'b01});
         for (int i = 0; i < int'($urandom_range(1, 8)); i++) begin
            send(8'($urandom), 1'b0);
            idle(int'($urandom_range(0, 3)));
         end
         drain();
      end

      // Async reset during DATA of 0xA3.
      wr_ctrl(32'h1);
      n0 = starts.size();
      send(8'hA3, 1'b1);
      send(8'h5A, 1'b1);
      wait_frames(n0 + 1);
      idle(35);
      abort_ok = 1;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_tx", {31'b0, tx}, 32'h1);
      check("rst_async_hit", {31'b0, hit}, 32'h0);
      check("rst_async_irq", {31'b0, irq}, 32'h0);
      idle(2);
      rst_n = 1'b1;
      cur_odd = 0;
      idle(2);
      rd(BASE + 32'h4, 32'h2, 1'b1, "status_after_rst");
      rd(BASE + 32'h8, 32'h1, 1'b1, "ctrl_after_rst");
      idle(FLEN + 20);
      check("frames_after_rst", starts.size() - n0, 32'd1);

      for (int i = 0; i < 4; i++) send(8'($urandom), 1'b1);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
